// File: rtl/xc_rng_pkg.sv
// Shared definitions for the XCrypto RNG back end: operation and status
// encodings, the health state type, the default LFSR feedback mask and small
// pure helpers used by both the LFSR and the unit.
package xc_rng_pkg;

    // Request operation encodings (3 is reserved and behaves like TEST).
    localparam logic [1:0] XC_RNG_OP_SEED = 2'd0;
    localparam logic [1:0] XC_RNG_OP_SAMP = 2'd1;
    localparam logic [1:0] XC_RNG_OP_TEST = 2'd2;

    // Response status encodings.
    localparam logic [1:0] XC_RNG_NOINIT    = 2'd0;
    localparam logic [1:0] XC_RNG_UNHEALTHY = 2'd1;
    localparam logic [1:0] XC_RNG_HEALTHY   = 2'd2;

    // Default Galois feedback mask.
    localparam logic [31:0] XC_RNG_LFSR_POLY = 32'h80200003;

    // Health / warm-up state.
    typedef enum logic [1:0] {
        XC_RNG_ST_NOINIT    = 2'd0,
        XC_RNG_ST_WARMUP    = 2'd1,
        XC_RNG_ST_HEALTHY   = 2'd2,
        XC_RNG_ST_UNHEALTHY = 2'd3
    } xc_rng_state_t;

    // One Galois LFSR step: shift right, fold the mask in when bit 0 was set.
    function automatic logic [31:0] xc_rng_lfsr_step(
        input logic [31:0] s,
        input logic [31:0] poly
    );
        logic [31:0] fb;
        fb = s[0] ? poly : 32'h0000_0000;
        return (s >> 1) ^ fb;
    endfunction

    // Output whitening: XOR of the value with two rotations of itself.
    function automatic logic [31:0] xc_rng_whiten(input logic [31:0] s);
        return s ^ {s[15:0], s[31:16]} ^ {s[7:0], s[31:8]};
    endfunction

    // Status reported for a given health state; warm-up still reads as NOINIT.
    function automatic logic [1:0] xc_rng_status_of(input xc_rng_state_t st);
        logic [1:0] r;
        case (st)
            XC_RNG_ST_NOINIT:    r = XC_RNG_NOINIT;
            XC_RNG_ST_WARMUP:    r = XC_RNG_NOINIT;
            XC_RNG_ST_HEALTHY:   r = XC_RNG_HEALTHY;
            XC_RNG_ST_UNHEALTHY: r = XC_RNG_UNHEALTHY;
            default:             r = XC_RNG_NOINIT;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/xc_rng_lfsr.sv
// 32-bit Galois LFSR with synchronous load and advance enable.
// Load has priority over advance; the zero flag feeds the health check.
module xc_rng_lfsr
    import xc_rng_pkg::*;
#(
    parameter logic [31:0] POLY        = XC_RNG_LFSR_POLY,
    parameter logic [31:0] RESET_STATE = 32'h0000_0000
) (
    input  logic        g_clk,
    input  logic        g_reset,
    input  logic        i_load,
    input  logic [31:0] i_load_data,
    input  logic        i_enable,
    output logic [31:0] o_state,
    output logic        o_zero
);

    logic [31:0] r_state;
    logic [31:0] w_state_nxt;

    // Next-state selection: load a new seed, advance, or hold.
    always_comb begin
        w_state_nxt = r_state;
        if (i_load) begin
            w_state_nxt = i_load_data;
        end else if (i_enable) begin
            w_state_nxt = xc_rng_lfsr_step(r_state, POLY);
        end else begin
            w_state_nxt = r_state;
        end
    end

    // LFSR state register.
    always_ff @(posedge g_clk or posedge g_reset) begin
        if (g_reset) begin
            r_state <= RESET_STATE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    assign o_state = r_state;
    assign o_zero  = (r_state == 32'h0000_0000);

endmodule

// File: rtl/xc_rng_unit.sv
// XCrypto RNG back end: owns the LFSR, the health / warm-up state machine and
// a single-outstanding request/response port serving rngseed, rngsamp and
// rngtest. Responses are registered (latency 1) and held until consumed.
// Optional build macro XC_RNG_WHITEN_EN: when defined, SAMP data is whitened
// combinationally on the way out; the LFSR state itself is never altered.
module xc_rng_unit
    import xc_rng_pkg::*;
#(
    parameter int unsigned WARMUP_CYCLES = 16,
    parameter logic [31:0] LFSR_POLY     = XC_RNG_LFSR_POLY,
    parameter logic [31:0] RESET_STATE   = 32'h0000_0000
) (
    input  logic        g_clk,
    input  logic        g_reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [31:0] req_data,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [1:0]  rsp_status,
    output logic [31:0] rsp_data
);

    // Warm-up is skipped entirely when WARMUP_CYCLES is zero.
    localparam bit          WARM_EN   = (WARMUP_CYCLES != 32'd0);
    localparam logic [31:0] WARM_LOAD = WARM_EN ? 32'(WARMUP_CYCLES - 32'd1) : 32'd0;

    xc_rng_state_t r_state;
    xc_rng_state_t w_state_nxt;
    logic [31:0]   r_warm_cnt;
    logic [31:0]   w_warm_cnt_nxt;

    logic          r_rsp_valid;
    logic [1:0]    r_rsp_status;
    logic [31:0]   r_rsp_data;
    logic [1:0]    w_rsp_status_nxt;
    logic [31:0]   w_rsp_data_nxt;

    logic          w_accept;
    logic          w_seed_acc;
    logic          w_seed_nz;
    logic          w_lfsr_en;
    logic [31:0]   w_lfsr_state;
    logic          w_lfsr_zero;
    logic [31:0]   w_samp_data;
    logic [1:0]    w_cur_status;

    // ------------------------------------------------------------------
    // Handshake decode
    // ------------------------------------------------------------------
    assign req_ready  = !r_rsp_valid && !g_reset;
    assign w_accept   = req_valid && req_ready;
    assign w_seed_acc = w_accept && (req_op == XC_RNG_OP_SEED);
    assign w_seed_nz  = (req_data != 32'h0000_0000);

    // ------------------------------------------------------------------
    // LFSR: runs only while warming up or healthy; a seed always wins.
    // ------------------------------------------------------------------
    assign w_lfsr_en = ((r_state == XC_RNG_ST_WARMUP) ||
                        (r_state == XC_RNG_ST_HEALTHY)) && !w_seed_acc;

    xc_rng_lfsr #(
        .POLY        (LFSR_POLY),
        .RESET_STATE (RESET_STATE)
    ) u_lfsr (
        .g_clk       (g_clk),
        .g_reset     (g_reset),
        .i_load      (w_seed_acc),
        .i_load_data (req_data),
        .i_enable    (w_lfsr_en),
        .o_state     (w_lfsr_state),
        .o_zero      (w_lfsr_zero)
    );

`ifdef XC_RNG_WHITEN_EN
    assign w_samp_data = xc_rng_whiten(w_lfsr_state);
`else
    assign w_samp_data = w_lfsr_state;
`endif

    // ------------------------------------------------------------------
    // Health FSM
    // ------------------------------------------------------------------

    // State register.
    always_ff @(posedge g_clk or posedge g_reset) begin
        if (g_reset) begin
            r_state <= XC_RNG_ST_NOINIT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: an accepted seed overrides warm-up completion and health check.
    always_comb begin
        w_state_nxt = r_state;
        if (w_seed_acc) begin
            if (w_seed_nz) begin
                w_state_nxt = WARM_EN ? XC_RNG_ST_WARMUP : XC_RNG_ST_HEALTHY;
            end else begin
                w_state_nxt = XC_RNG_ST_UNHEALTHY;
            end
        end else begin
            case (r_state)
                XC_RNG_ST_NOINIT: begin
                    w_state_nxt = XC_RNG_ST_NOINIT;
                end
                XC_RNG_ST_WARMUP: begin
                    if (r_warm_cnt == 32'd0) begin
                        w_state_nxt = XC_RNG_ST_HEALTHY;
                    end else begin
                        w_state_nxt = XC_RNG_ST_WARMUP;
                    end
                end
                XC_RNG_ST_HEALTHY: begin
                    if (w_lfsr_zero) begin
                        w_state_nxt = XC_RNG_ST_UNHEALTHY;
                    end else begin
                        w_state_nxt = XC_RNG_ST_HEALTHY;
                    end
                end
                XC_RNG_ST_UNHEALTHY: begin
                    w_state_nxt = XC_RNG_ST_UNHEALTHY;
                end
                default: begin
                    w_state_nxt = XC_RNG_ST_NOINIT;
                end
            endcase
        end
    end

    // Status reported for the current state.
    always_comb begin
        w_cur_status = xc_rng_status_of(r_state);
    end

    // ------------------------------------------------------------------
    // Warm-up counter
    // ------------------------------------------------------------------

    // Reload on a non-zero seed, count down while warming up, else hold.
    always_comb begin
        w_warm_cnt_nxt = r_warm_cnt;
        if (w_seed_acc && w_seed_nz) begin
            w_warm_cnt_nxt = WARM_LOAD;
        end else if ((r_state == XC_RNG_ST_WARMUP) && (r_warm_cnt != 32'd0)) begin
            w_warm_cnt_nxt = r_warm_cnt - 32'd1;
        end else begin
            w_warm_cnt_nxt = r_warm_cnt;
        end
    end

    // Warm-up counter register.
    always_ff @(posedge g_clk or posedge g_reset) begin
        if (g_reset) begin
            r_warm_cnt <= 32'd0;
        end else begin
            r_warm_cnt <= w_warm_cnt_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Response
    // ------------------------------------------------------------------

    // Response payload for the request being accepted this cycle.
    always_comb begin
        w_rsp_status_nxt = w_cur_status;
        w_rsp_data_nxt   = 32'h0000_0000;
        case (req_op)
            XC_RNG_OP_SEED: begin
                if (w_seed_nz) begin
                    w_rsp_status_nxt = WARM_EN ? XC_RNG_NOINIT : XC_RNG_HEALTHY;
                end else begin
                    w_rsp_status_nxt = XC_RNG_UNHEALTHY;
                end
            end
            XC_RNG_OP_SAMP: begin
                if (r_state == XC_RNG_ST_HEALTHY) begin
                    if (w_lfsr_zero) begin
                        // Stuck-at-zero detected on this very cycle.
                        w_rsp_status_nxt = XC_RNG_UNHEALTHY;
                        w_rsp_data_nxt   = 32'h0000_0000;
                    end else begin
                        w_rsp_status_nxt = XC_RNG_HEALTHY;
                        w_rsp_data_nxt   = w_samp_data;
                    end
                end else begin
                    w_rsp_status_nxt = w_cur_status;
                    w_rsp_data_nxt   = 32'h0000_0000;
                end
            end
            default: begin
                // TEST and the reserved encoding only report status.
                w_rsp_status_nxt = w_cur_status;
                w_rsp_data_nxt   = 32'h0000_0000;
            end
        endcase
    end

    // Response register: load on accept, clear valid once consumed.
    always_ff @(posedge g_clk or posedge g_reset) begin
        if (g_reset) begin
            r_rsp_valid  <= 1'b0;
            r_rsp_status <= 2'd0;
            r_rsp_data   <= 32'h0000_0000;
        end else if (w_accept) begin
            r_rsp_valid  <= 1'b1;
            r_rsp_status <= w_rsp_status_nxt;
            r_rsp_data   <= w_rsp_data_nxt;
        end else if (r_rsp_valid && rsp_ready) begin
            r_rsp_valid  <= 1'b0;
            r_rsp_status <= r_rsp_status;
            r_rsp_data   <= r_rsp_data;
        end else begin
            r_rsp_valid  <= r_rsp_valid;
            r_rsp_status <= r_rsp_status;
            r_rsp_data   <= r_rsp_data;
        end
    end

    assign rsp_valid  = r_rsp_valid;
    assign rsp_status = r_rsp_status;
    assign rsp_data   = r_rsp_data;

endmodule

// File: tb/tb_xc_rng_unit.sv
// Self-checking bench for xc_rng_unit: table of requests with expected status,
// sample data from a reference LFSR model, a scoreboard queue popped when a
// response is consumed, plus hand-written stall and mid-response reset cases.
`timescale 1ns/1ps
module tb_xc_rng_unit;

    localparam int          WARM = 16;
    localparam logic [31:0] POLY = 32'h80200003;

    localparam logic [1:0] OP_SEED = 2'd0;
    localparam logic [1:0] OP_SAMP = 2'd1;
    localparam logic [1:0] OP_TEST = 2'd2;
    localparam logic [1:0] OP_RSVD = 2'd3;

    logic        g_clk = 1'b0;
    logic        g_reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_op = 2'd0;
    logic [31:0] req_data = 32'h0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [1:0]  rsp_status;
    logic [31:0] rsp_data;

    xc_rng_unit #(
        .WARMUP_CYCLES (WARM),
        .LFSR_POLY     (POLY),
        .RESET_STATE   (32'h0000_0000)
    ) dut (
        .g_clk      (g_clk),
        .g_reset    (g_reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_data   (req_data),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_status (rsp_status),
        .rsp_data   (rsp_data)
    );

    always #5 g_clk = ~g_clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] data;
        int          idle;
        logic [1:0]  st;
        bit          use_model;
    } vec_t;

    typedef struct {
        logic [1:0]  st;
        logic [31:0] data;
    } exp_t;

    vec_t        tbl [20];
    exp_t        exp_q [$];
    int          n_cmp = 0;
    int          n_fail = 0;
    int          cyc = 0;
    logic [31:0] m_seed = 32'h0;
    int          m_seed_edge = 0;

    function automatic logic [31:0] ref_adv(input logic [31:0] s0, input int n);
        logic [31:0] s;
        s = s0;
        for (int i = 0; i < n; i++) begin
            s = (s >> 1) ^ (s[0] ? POLY : 32'h0);
        end
        return s;
    endfunction

    function automatic logic [31:0] ref_out(input logic [31:0] s);
`ifdef XC_RNG_WHITEN_EN
        return s ^ {s[15:0], s[31:16]} ^ {s[7:0], s[31:8]};
`else
        return s;
`endif
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Drive one request; expected response is pushed when it is driven.
    task automatic issue(input logic [1:0] op, input logic [31:0] d, input int idle,
                         input logic [1:0] st_exp, input bit use_model);
        int   guard;
        int   k;
        exp_t e;
        repeat (idle) @(posedge g_clk);
        if (idle > 0) #2;
        guard = 0;
        while (!req_ready && guard < 64) begin
            @(posedge g_clk);
            #2;
            guard++;
        end
        if (!req_ready) begin
            n_cmp++;
            n_fail++;
            $display("FAIL issue_timeout: req_ready stayed %b, expected 1", req_ready);
            return;
        end
        req_valid = 1'b1;
        req_op    = op;
        req_data  = d;
        e.st   = st_exp;
        e.data = 32'h0;
        if (use_model) begin
            k = cyc - m_seed_edge;
            e.data = ref_out(ref_adv(m_seed, k - 1));
        end
        exp_q.push_back(e);
        if (op == OP_SEED) begin
            m_seed      = d;
            m_seed_edge = cyc;
        end
        @(posedge g_clk);
        #2;
        req_valid = 1'b0;
        check32("rsp_latency", {31'h0, rsp_valid}, 32'd1);
    endtask

    // Edge counter, read between edges.
    initial forever begin
        @(posedge g_clk);
        cyc++;
    end

    // Scoreboard monitor: a response is consumed at the posedge after this negedge.
    initial forever begin
        exp_t e;
        @(negedge g_clk);
        if (!g_reset && rsp_valid && rsp_ready) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected: got st=%0d data=%h, expected no response", rsp_status, rsp_data);
            end else begin
                e = exp_q.pop_front();
                if (rsp_status !== e.st || rsp_data !== e.data) begin
                    n_fail++;
                    $display("FAIL sb_rsp: got st=%0d data=%h, expected st=%0d data=%h",
                             rsp_status, rsp_data, e.st, e.data);
                end
            end
        end
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        logic [1:0]  cap_st;
        logic [31:0] cap_dt;

        //              op       data          idle st     model
        tbl[0]  = '{OP_TEST, 32'h0000_0000,  0, 2'd0, 1'b0};
        tbl[1]  = '{OP_SEED, 32'hDEAD_BEEF,  0, 2'd0, 1'b0};
        tbl[2]  = '{OP_SAMP, 32'h0000_0000,  2, 2'd0, 1'b0};
        tbl[3]  = '{OP_TEST, 32'h0000_0000, 14, 2'd2, 1'b0};
        tbl[4]  = '{OP_SAMP, 32'h0000_0000,  0, 2'd2, 1'b1};
        tbl[5]  = '{OP_SAMP, 32'h5555_AAAA,  5, 2'd2, 1'b1};
        tbl[6]  = '{OP_RSVD, 32'hFFFF_FFFF,  0, 2'd2, 1'b0};
        tbl[7]  = '{OP_SEED, 32'h0000_0000,  0, 2'd1, 1'b0};
        tbl[8]  = '{OP_SAMP, 32'h0000_0000,  0, 2'd1, 1'b0};
        tbl[9]  = '{OP_TEST, 32'h0000_0000,  0, 2'd1, 1'b0};
        tbl[10] = '{OP_SEED, 32'h0000_0001,  0, 2'd0, 1'b0};
        tbl[11] = '{OP_TEST, 32'h0000_0000,  0, 2'd0, 1'b0};
        tbl[12] = '{OP_TEST, 32'h0000_0000, 20, 2'd2, 1'b0};
        tbl[13] = '{OP_SAMP, 32'h0000_0000,  0, 2'd2, 1'b1};
        tbl[14] = '{OP_SEED, 32'h1234_5678,  0, 2'd0, 1'b0};
        tbl[15] = '{OP_SAMP, 32'h0000_0000,  0, 2'd0, 1'b0};
        tbl[16] = '{OP_SEED, 32'hDEAD_BEEF,  0, 2'd0, 1'b0};
        tbl[17] = '{OP_SAMP, 32'h0000_0000, 15, 2'd0, 1'b0};
        tbl[18] = '{OP_SEED, 32'hDEAD_BEEF,  0, 2'd0, 1'b0};
        tbl[19] = '{OP_SAMP, 32'h0000_0000, 16, 2'd2, 1'b1};

        // Reset values while reset is held.
        repeat (3) @(posedge g_clk);
        #2;
        check32("rst_rsp_valid",  {31'h0, rsp_valid},  32'd0);
        check32("rst_req_ready",  {31'h0, req_ready},  32'd0);
        check32("rst_rsp_status", {30'h0, rsp_status}, 32'd0);
        check32("rst_rsp_data",   rsp_data,            32'h0);
        g_reset = 1'b0;
        #1;
        check32("rel_req_ready",  {31'h0, req_ready},  32'd1);
        @(posedge g_clk);
        #2;

        for (int i = 0; i < 20; i++) begin
            issue(tbl[i].op, tbl[i].data, tbl[i].idle, tbl[i].st, tbl[i].use_model);
        end

        // Consumer stall: response must hold and block new requests.
        @(posedge g_clk);
        #2;
        rsp_ready = 1'b0;
        issue(OP_SAMP, 32'h0, 0, 2'd2, 1'b1);
        cap_st = rsp_status;
        cap_dt = rsp_data;
        for (int i = 0; i < 5; i++) begin
            @(negedge g_clk);
            check32("stall_valid",  {31'h0, rsp_valid},  32'd1);
            check32("stall_ready",  {31'h0, req_ready},  32'd0);
            check32("stall_status", {30'h0, rsp_status}, {30'h0, cap_st});
            check32("stall_data",   rsp_data,            cap_dt);
        end
        @(posedge g_clk);
        #2;
        rsp_ready = 1'b1;
        @(posedge g_clk);
        #2;
        check32("stall_release", {31'h0, rsp_valid}, 32'd0);

        // Reset during warm-up with a response pending.
        issue(OP_SEED, 32'hCAFE_F00D, 0, 2'd0, 1'b0);
        @(posedge g_clk);
        #2;
        rsp_ready = 1'b0;
        issue(OP_TEST, 32'h0, 0, 2'd0, 1'b0);
        check32("pend_valid", {31'h0, rsp_valid}, 32'd1);
        #1;
        g_reset = 1'b1;
        #1;
        check32("rst_mid_valid", {31'h0, rsp_valid}, 32'd0);
        check32("rst_mid_ready", {31'h0, req_ready}, 32'd0);
        exp_q.delete();
        @(posedge g_clk);
        #2;
        g_reset   = 1'b0;
        rsp_ready = 1'b1;
        issue(OP_TEST, 32'h0, 2, 2'd0, 1'b0);
        issue(OP_SAMP, 32'h0, 0, 2'd0, 1'b0);

        repeat (3) @(posedge g_clk);
        #2;
        check32("sb_drain", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
